wave_capture: RTL

WAVE_CAPTURE -- requirements
Module: wave_capture

---
 rtl/wave_capture_pkg.sv | 20 ++
 rtl/wave_capture_ram.sv | 45 ++++
 rtl/wave_capture.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/wave_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wave_capture_pkg
// Description : Shared sizing defaults and state encodings for the waveform
//               capture block and its processor register interface.
// Revision    : 1.0 - initial release
// ============================================================================
package wave_capture_pkg;

    localparam int c_DATA_W = 12;
    localparam int c_DEPTH  = 256;
    localparam int c_ADDR_W = 8;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

endpackage : wave_capture_pkg
`default_nettype wire

// File: rtl/wave_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : wave_capture_ram
// Description : Simple dual-port sample buffer, one write port and one
//               registered read port with read-old-data on collision.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_capture_ram
    import wave_capture_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Memory array carries no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : wave_capture_ram
`default_nettype wire

// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module      : wave_capture
// Description : Triggered waveform capture: arms, waits for a level crossing
//               or forced trigger, then records DEPTH samples into a buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_vld;
    logic              r_rd_valid;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] w_prev_nxt;
    logic              w_prev_vld_nxt;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_rise;
    logic              w_fall;
    logic              w_trig;

    assign w_rise = (r_prev < trig_level) && (in_sample >= trig_level);
    assign w_fall = (r_prev > trig_level) && (in_sample <= trig_level);
    assign w_trig = r_prev_vld && (trig_slope ? w_fall : w_rise);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_prev     <= w_prev_nxt;
            r_prev_vld <= w_prev_vld_nxt;
            r_rd_valid <= rd_en;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_prev_nxt     = r_prev;
        w_prev_vld_nxt = r_prev_vld;
        w_we           = 1'b0;
        w_waddr        = r_cnt;

        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                // arm wins over a simultaneous force_trig here
                if (arm) begin
                    w_state_nxt    = c_ST_ARMED;
                    w_cnt_nxt      = '0;
                    w_prev_vld_nxt = 1'b0;
                end
            end
            c_ST_ARMED: begin
                if (arm) begin
                    w_cnt_nxt      = '0;
                    w_prev_vld_nxt = 1'b0;
                end else if (force_trig || (in_valid && w_trig)) begin
                    w_state_nxt = c_ST_CAPTURE;
                    if (in_valid) begin
                        w_we      = 1'b1;
                        w_waddr   = '0;
                        w_cnt_nxt = ADDR_W'(1);
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end else if (in_valid) begin
                    w_prev_nxt     = in_sample;
                    w_prev_vld_nxt = 1'b1;
                end
            end
            c_ST_CAPTURE: begin
                if (in_valid) begin
                    w_we = 1'b1;
                    if (r_cnt == c_LAST_ADDR) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    wave_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (in_sample),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == c_ST_ARMED) || (r_state == c_ST_CAPTURE);
    assign done     = (r_state == c_ST_DONE);
    assign state    = r_state;

endmodule : wave_capture
`default_nettype wire
